// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

   localparam int MS_W = 14;

   localparam logic [MS_W-1:0] MIN_DELAY_MS = 14'd1000;
   localparam logic [MS_W-1:0] MAX_DELAY_MS = 14'd5000;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RND,
      DELAY,
      REACT,
      DONE,
      EARLY
   } state_t;

   function automatic logic [MS_W-1:0] clamp_delay(input logic [MS_W-1:0] value);
      if (value < MIN_DELAY_MS)
         return MIN_DELAY_MS;
      else if (value > MAX_DELAY_MS)
         return MAX_DELAY_MS;
      else
         return value;
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_PER_MS cycles, restartable via clr.
module ms_tick_gen #(
   parameter int CLK_PER_MS = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int              CNT_W = $clog2(CLK_PER_MS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_MS - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   // Tick is active during the last prescaler cycle, so the consumer acts on
   // the edge that completes the millisecond.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: random delay, LED on, reaction measurement,
// false-start and timeout detection.
module reaction_ctrl
   import reaction_pkg::*;
#(
   parameter int CLK_PER_MS = 50000,
   parameter int MAX_MS     = 9999
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            button,
   input  logic [MS_W-1:0] rnd_value,
   input  logic            rnd_ready,
   output logic            led,
   output logic [MS_W-1:0] rt_ms,
   output logic            rt_valid,
   output logic            early,
   output logic            timeout,
   output logic            busy
);

   localparam logic [MS_W-1:0] MAX_MS_V  = MS_W'(MAX_MS);
   localparam logic [MS_W-1:0] MAX_MS_M1 = MS_W'(MAX_MS - 1);

   state_t          state, next_state;
   logic            button_q;
   logic            press;
   logic            tick;
   logic            tick_clr;
   logic [MS_W-1:0] delay_ms;
   logic [MS_W-1:0] ms_cnt;
   logic [MS_W-1:0] rt_q;
   logic            rt_valid_q, early_q, timeout_q;

   logic            load_delay, clear_results, take_result, take_timeout, set_early;

   ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (tick_clr),
      .tick  (tick)
   );

   assign press = button & ~button_q;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // NOTE: every signal written here gets a default first, so no latches are inferred.
   always_comb begin
      next_state    = state;
      tick_clr      = 1'b0;
      load_delay    = 1'b0;
      clear_results = 1'b0;
      take_result   = 1'b0;
      take_timeout  = 1'b0;
      set_early     = 1'b0;
      case (state)
         IDLE, DONE, EARLY: begin
            if (start) begin
               next_state    = WAIT_RND;
               clear_results = 1'b1;
            end
         end
         WAIT_RND: begin
            if (press) begin
               next_state = EARLY;
               set_early  = 1'b1;
            end else if (rnd_ready) begin
               next_state = DELAY;
               load_delay = 1'b1;
               tick_clr   = 1'b1;
            end
         end
         DELAY: begin
            if (press) begin
               next_state = EARLY;
               set_early  = 1'b1;
            end else if (tick && delay_ms == MS_W'(1)) begin
               next_state = REACT;
               tick_clr   = 1'b1;
            end
         end
         REACT: begin
            if (press) begin
               next_state  = DONE;
               take_result = 1'b1;
            end else if (tick && ms_cnt >= MAX_MS_M1) begin
               next_state   = DONE;
               take_timeout = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         button_q   <= 1'b0;
         delay_ms   <= '0;
         ms_cnt     <= '0;
         rt_q       <= '0;
         rt_valid_q <= 1'b0;
         early_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         button_q <= button;

         if (load_delay)
            delay_ms <= clamp_delay(rnd_value);
         else if (state == DELAY && tick && delay_ms > MS_W'(1))
            delay_ms <= delay_ms - MS_W'(1);

         if (state == DELAY && tick && delay_ms == MS_W'(1))
            ms_cnt <= '0;
         else if (state == REACT && tick && ms_cnt < MAX_MS_V)
            ms_cnt <= ms_cnt + MS_W'(1);

         if (clear_results) begin
            rt_q       <= '0;
            rt_valid_q <= 1'b0;
            early_q    <= 1'b0;
            timeout_q  <= 1'b0;
         end

         // A press coinciding with a tick counts that tick, which also makes a
         // press on the timeout tick report MAX_MS as a valid time.
         if (take_result) begin
            rt_q       <= (tick && ms_cnt < MAX_MS_V) ? ms_cnt + MS_W'(1) : ms_cnt;
            rt_valid_q <= 1'b1;
         end

         if (take_timeout) begin
            rt_q      <= MAX_MS_V;
            timeout_q <= 1'b1;
         end

         if (set_early)
            early_q <= 1'b1;
      end
   end

   assign led      = (state == REACT);
   assign busy     = (state inside {WAIT_RND, DELAY, REACT});
   assign rt_ms    = rt_q;
   assign rt_valid = rt_valid_q;
   assign early    = early_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl: table-driven rounds with a result
// scoreboard, plus hand-written false-start, held-button and reset sequences.
module tb_reaction_ctrl;
   import reaction_pkg::*;

   localparam int CPM   = 10;
   localparam int MAXMS = 50;

   localparam int S_LED = 0;
   localparam int S_TMO = 1;

   logic            clk = 1'b0;
   logic            reset, start, button, rnd_ready;
   logic [MS_W-1:0] rnd_value;
   logic            led, rt_valid, early, timeout, busy;
   logic [MS_W-1:0] rt_ms;

   always #5 clk = ~clk;

   reaction_ctrl #(.CLK_PER_MS(CPM), .MAX_MS(MAXMS)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .button    (button),
      .rnd_value (rnd_value),
      .rnd_ready (rnd_ready),
      .led       (led),
      .rt_ms     (rt_ms),
      .rt_valid  (rt_valid),
      .early     (early),
      .timeout   (timeout),
      .busy      (busy)
   );

   typedef struct {
      logic [MS_W-1:0] rt;
      logic            valid;
      logic            tmo;
      logic            early;
   } res_t;

   typedef struct {
      logic [MS_W-1:0] rnd;
      int              ready_delay;
      int              press_at;
      int              delay_ms;
      logic [MS_W-1:0] rt;
      logic            valid;
      logic            tmo;
   } vec_t;

   res_t sb[$];
   vec_t vecs[3];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         S_LED:   return led;
         S_TMO:   return timeout;
         default: return 1'b0;
      endcase
   endfunction

   // Counts negedges until the selected output is high; -1 if the budget expires.
   task automatic wait_high(input int sel, input int budget, output int n);
      n = 0;
      while (!sig(sel) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!sig(sel))
         n = -1;
   endtask

   task automatic compare_result(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_rt_ms"},    32'(rt_ms),    32'(e.rt));
         check({tag, "_rt_valid"}, 32'(rt_valid), 32'(e.valid));
         check({tag, "_timeout"},  32'(timeout),  32'(e.tmo));
         check({tag, "_early"},    32'(early),    32'(e.early));
      end
   endtask

   task automatic run_round(input int idx, input vec_t v);
      int    n;
      string tag;
      tag = $sformatf("v%0d", idx);
      sb.push_back('{v.rt, v.valid, v.tmo, 1'b0});
      rnd_value = v.rnd;
      rnd_ready = (v.ready_delay == 0);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      if (v.ready_delay > 0) begin
         repeat (v.ready_delay) @(negedge clk);
         check({tag, "_still_waiting"}, 32'({busy, led}), 32'b10);
      end
      rnd_ready = 1'b1;
      wait_high(S_LED, v.delay_ms * CPM + 50, n);
      check({tag, "_led_delay"}, 32'(n), 32'(v.delay_ms * CPM + 1));
      if (v.press_at > 0) begin
         repeat (v.press_at - 1) @(negedge clk);
         button = 1'b1;
         @(negedge clk);
         check({tag, "_rt_valid_latency"}, 32'(rt_valid), 32'd1);
         check({tag, "_led_off"}, 32'(led), 32'd0);
         button = 1'b0;
      end else begin
         wait_high(S_TMO, MAXMS * CPM + 20, n);
         check({tag, "_timeout_time"}, 32'(n), 32'(MAXMS * CPM));
         check({tag, "_led_off"}, 32'(led), 32'd0);
      end
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      compare_result(tag);
      rnd_ready = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int   n;
      logic led_seen;

      vecs[0] = '{14'd1000,  0,  73, 1000, 14'd7,  1'b1, 1'b0};
      vecs[1] = '{14'd200,  20,   0, 1000, 14'd50, 1'b0, 1'b1};
      vecs[2] = '{14'd9000,  0, 500, 5000, 14'd50, 1'b1, 1'b0};

      reset     = 1'b1;
      start     = 1'b0;
      button    = 1'b0;
      rnd_ready = 1'b0;
      rnd_value = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_led",      32'(led),      32'd0);
      check("reset_busy",     32'(busy),     32'd0);
      check("reset_rt_ms",    32'(rt_ms),    32'd0);
      check("reset_rt_valid", 32'(rt_valid), 32'd0);
      check("reset_early",    32'(early),    32'd0);
      check("reset_timeout",  32'(timeout),  32'd0);

      for (int i = 0; i < 3; i++)
         run_round(i, vecs[i]);

      // Results hold in DONE until the next start.
      repeat (10) @(negedge clk);
      check("hold_rt_ms", 32'(rt_ms), 32'd50);

      // False start 500 cycles into DELAY; start also clears the previous result.
      sb.push_back('{14'd0, 1'b0, 1'b0, 1'b1});
      rnd_value = 14'd3000;
      rnd_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      repeat (499) @(negedge clk);
      button = 1'b1;
      @(negedge clk);
      check("early_flag", 32'(early), 32'd1);
      check("early_busy", 32'(busy),  32'd0);
      led_seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         led_seen = led_seen | led;
      end
      check("early_led_never", 32'(led_seen), 32'd0);
      button = 1'b0;
      compare_result("early");

      // Button held across start, released in DELAY; start pulsed during DELAY.
      button = 1'b1;
      repeat (3) @(negedge clk);
      rnd_value = 14'd1000;
      rnd_ready = 1'b1;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("held_busy", 32'(busy), 32'd1);
      n = 0;
      while (!led && n < 20000) begin
         @(negedge clk);
         n++;
         button = (n < 5);
         start  = (n == 20);
      end
      start = 1'b0;
      check("held_led_delay", 32'(n), 32'd10001);
      check("held_no_early",  32'(early), 32'd0);

      // Reset in REACT aborts at once.
      repeat (30) @(negedge clk);
      check("react_led_on", 32'(led), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_outputs", 32'({led, busy, rt_valid, early, timeout, rt_ms}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got time limit reached expected test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
